// File: rtl/instruction_fetch_unit_if.sv
// Instruction cache request/response bus between the IF stage and the I-cache.
// master: drives imem_req/imem_addr, samples imem_ready/imem_data.
interface instruction_fetch_unit_if #(
   parameter int WORD_SIZE = 16
);
   logic                 imem_req;
   logic [WORD_SIZE-1:0] imem_addr;
   logic                 imem_ready;
   logic [WORD_SIZE-1:0] imem_data;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_data
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_data
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// IF stage: holds the PC, fetches from the I-cache, follows BTB predictions.
// Ports: clk/reset_n, stall_id, redirect, BTB lookup, imem bus, IF/ID outputs.
module instruction_fetch_unit #(
   parameter int                   WORD_SIZE = 16,
   parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 stall_id,
   input  logic                 redirect_valid,
   input  logic [WORD_SIZE-1:0] redirect_pc,
   output logic [WORD_SIZE-1:0] btb_read_addr,
   input  logic [WORD_SIZE-1:0] btb_read_data,
   instruction_fetch_unit_if.master imem,
   output logic                 if_valid,
   output logic [WORD_SIZE-1:0] if_inst,
   output logic [WORD_SIZE-1:0] if_pc,
   output logic [WORD_SIZE-1:0] if_pc_plus_one,
   output logic [WORD_SIZE-1:0] if_pred_next
);

   localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1);

   typedef enum logic [1:0] {
      S_FETCH,
      S_HOLD,
      S_DRAIN
   } state_t;

   state_t               state_q, state_d;
   logic [WORD_SIZE-1:0] pc_q, pc_d;
   logic [WORD_SIZE-1:0] drain_q, drain_d;

   logic [WORD_SIZE-1:0] buf_inst_q, buf_inst_d;
   logic [WORD_SIZE-1:0] buf_pc_q, buf_pc_d;
   logic [WORD_SIZE-1:0] buf_pc1_q, buf_pc1_d;
   logic [WORD_SIZE-1:0] buf_pred_q, buf_pred_d;

   logic                 ifv_q, ifv_d;
   logic [WORD_SIZE-1:0] ifi_q, ifi_d;
   logic [WORD_SIZE-1:0] ifp_q, ifp_d;
   logic [WORD_SIZE-1:0] ifp1_q, ifp1_d;
   logic [WORD_SIZE-1:0] ifn_q, ifn_d;

   logic [WORD_SIZE-1:0] pc_plus_one;

   assign pc_plus_one = pc_q + ONE;

   // Request is gated by reset so the cache sees it drop immediately.
   assign imem.imem_req  = reset_n & (state_q != S_HOLD);
   assign imem.imem_addr = (state_q == S_DRAIN) ? drain_q : pc_q;
   assign btb_read_addr  = pc_q;

   assign if_valid       = ifv_q;
   assign if_inst        = ifi_q;
   assign if_pc          = ifp_q;
   assign if_pc_plus_one = ifp1_q;
   assign if_pred_next   = ifn_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      drain_d    = drain_q;
      buf_inst_d = buf_inst_q;
      buf_pc_d   = buf_pc_q;
      buf_pc1_d  = buf_pc1_q;
      buf_pred_d = buf_pred_q;
      ifv_d      = ifv_q;
      ifi_d      = ifi_q;
      ifp_d      = ifp_q;
      ifp1_d     = ifp1_q;
      ifn_d      = ifn_q;
      unique case (state_q)
         S_FETCH: begin
            if (redirect_valid) begin
               ifv_d = 1'b0;
               pc_d  = redirect_pc;
               // An outstanding miss must still complete; its data is junk.
               if (!imem.imem_ready) begin
                  drain_d = pc_q;
                  state_d = S_DRAIN;
               end
            end else if (imem.imem_ready) begin
               pc_d = btb_read_data;
               if (stall_id) begin
                  buf_inst_d = imem.imem_data;
                  buf_pc_d   = pc_q;
                  buf_pc1_d  = pc_plus_one;
                  buf_pred_d = btb_read_data;
                  state_d    = S_HOLD;
               end else begin
                  ifv_d  = 1'b1;
                  ifi_d  = imem.imem_data;
                  ifp_d  = pc_q;
                  ifp1_d = pc_plus_one;
                  ifn_d  = btb_read_data;
               end
            end else if (!stall_id) begin
               ifv_d = 1'b0;
            end
         end
         S_HOLD: begin
            if (redirect_valid || !stall_id) begin
               buf_inst_d = '0;
               buf_pc_d   = '0;
               buf_pc1_d  = '0;
               buf_pred_d = '0;
               state_d    = S_FETCH;
            end
            if (redirect_valid) begin
               ifv_d = 1'b0;
               pc_d  = redirect_pc;
            end else if (!stall_id) begin
               ifv_d  = 1'b1;
               ifi_d  = buf_inst_q;
               ifp_d  = buf_pc_q;
               ifp1_d = buf_pc1_q;
               ifn_d  = buf_pred_q;
            end
         end
         S_DRAIN: begin
            ifv_d = 1'b0;
            if (redirect_valid) begin
               pc_d = redirect_pc;
            end
            if (imem.imem_ready) begin
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_FETCH;
         pc_q       <= RESET_PC;
         drain_q    <= '0;
         buf_inst_q <= '0;
         buf_pc_q   <= '0;
         buf_pc1_q  <= '0;
         buf_pred_q <= '0;
         ifv_q      <= 1'b0;
         ifi_q      <= '0;
         ifp_q      <= '0;
         ifp1_q     <= '0;
         ifn_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         drain_q    <= drain_d;
         buf_inst_q <= buf_inst_d;
         buf_pc_q   <= buf_pc_d;
         buf_pc1_q  <= buf_pc1_d;
         buf_pred_q <= buf_pred_d;
         ifv_q      <= ifv_d;
         ifi_q      <= ifi_d;
         ifp_q      <= ifp_d;
         ifp1_q     <= ifp1_d;
         ifn_q      <= ifn_d;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed cache/BTB stimulus,
// transaction-level model, per-cycle compare and literal spot checks.
module tb_instruction_fetch_unit;

   logic        clk;
   logic        reset_n;
   logic        stall_id;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic [15:0] btb_read_addr;
   logic [15:0] btb_read_data;
   logic        if_valid;
   logic [15:0] if_inst;
   logic [15:0] if_pc;
   logic [15:0] if_pc_plus_one;
   logic [15:0] if_pred_next;
   logic        ready_r;
   logic        btb_en;

   int checks = 0;
   int errors = 0;

   instruction_fetch_unit_if #(.WORD_SIZE(16)) imem_bus ();

   instruction_fetch_unit #(
      .WORD_SIZE(16),
      .RESET_PC (16'h0000)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .stall_id      (stall_id),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .btb_read_addr (btb_read_addr),
      .btb_read_data (btb_read_data),
      .imem          (imem_bus),
      .if_valid      (if_valid),
      .if_inst       (if_inst),
      .if_pc         (if_pc),
      .if_pc_plus_one(if_pc_plus_one),
      .if_pred_next  (if_pred_next)
   );

   function automatic logic [15:0] mem_f(input logic [15:0] a);
      return a ^ 16'hC300;
   endfunction

   function automatic logic [15:0] btb_f(input logic [15:0] a,
                                         input logic en);
      if (en && a == 16'h0003) return 16'h0020;
      return a + 16'h0001;
   endfunction

   assign imem_bus.imem_ready = ready_r;
   assign imem_bus.imem_data  = mem_f(imem_bus.imem_addr);
   assign btb_read_data       = btb_f(btb_read_addr, btb_en);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   // Model: the PC, a parked instruction awaiting decode, a flag for an
   // abandoned cache access still to complete, and the IF/ID contents.
   logic [15:0] m_pc, m_daddr, m_inst, m_ifpc, m_pred;
   logic [15:0] b_inst, b_pc, b_pred;
   logic        m_buf_full, m_discard, m_ifv;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_pc       <= 16'h0000;
         m_daddr    <= 16'h0000;
         m_buf_full <= 1'b0;
         m_discard  <= 1'b0;
         m_ifv      <= 1'b0;
         m_inst     <= 16'h0;
         m_ifpc     <= 16'h0;
         m_pred     <= 16'h0;
      end else if (redirect_valid) begin
         m_ifv <= 1'b0;
         m_pc  <= redirect_pc;
         if (m_buf_full) m_buf_full <= 1'b0;
         else if (ready_r) m_discard <= 1'b0;
         else if (!m_discard) begin
            m_discard <= 1'b1;
            m_daddr   <= m_pc;
         end
      end else if (m_buf_full) begin
         if (!stall_id) begin
            m_buf_full <= 1'b0;
            m_ifv      <= 1'b1;
            m_inst     <= b_inst;
            m_ifpc     <= b_pc;
            m_pred     <= b_pred;
         end
      end else if (m_discard) begin
         m_ifv <= 1'b0;
         if (ready_r) m_discard <= 1'b0;
      end else if (ready_r) begin
         m_pc <= btb_f(m_pc, btb_en);
         if (stall_id) begin
            m_buf_full <= 1'b1;
            b_inst     <= mem_f(m_pc);
            b_pc       <= m_pc;
            b_pred     <= btb_f(m_pc, btb_en);
         end else begin
            m_ifv  <= 1'b1;
            m_inst <= mem_f(m_pc);
            m_ifpc <= m_pc;
            m_pred <= btb_f(m_pc, btb_en);
         end
      end else if (!stall_id) begin
         m_ifv <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (reset_n) begin
         chk("req", 16'(imem_bus.imem_req), 16'(!m_buf_full));
         if (!m_buf_full)
            chk("addr", imem_bus.imem_addr, m_discard ? m_daddr : m_pc);
         chk("btb_addr", btb_read_addr, m_pc);
         chk("if_valid", 16'(if_valid), 16'(m_ifv));
         if (m_ifv) begin
            chk("if_inst", if_inst, m_inst);
            chk("if_pc", if_pc, m_ifpc);
            chk("if_pc1", if_pc_plus_one, m_ifpc + 16'h0001);
            chk("if_pred", if_pred_next, m_pred);
         end
      end
   end

   task automatic step(input logic rdy, input logic st, input logic rd,
                       input logic [15:0] rpc);
      @(posedge clk);
      #1;
      ready_r        = rdy;
      stall_id       = st;
      redirect_valid = rd;
      redirect_pc    = rpc;
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_req"}, 16'(imem_bus.imem_req), 16'h0);
      chk({tag, "_valid"}, 16'(if_valid), 16'h0);
      chk({tag, "_inst"}, if_inst, 16'h0);
      chk({tag, "_pc"}, if_pc, 16'h0);
      chk({tag, "_pc1"}, if_pc_plus_one, 16'h0);
      chk({tag, "_pred"}, if_pred_next, 16'h0);
      chk({tag, "_btb"}, btb_read_addr, 16'h0);
   endtask

   initial begin
      reset_n        = 1'b0;
      ready_r        = 1'b0;
      stall_id       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0;
      btb_en         = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero("rst");
      @(posedge clk);
      #1 reset_n = 1'b1;

      // back-to-back hits, BTB predicts pc+1
      step(1, 0, 0, 16'h0);
      chk("hit_a0", imem_bus.imem_addr, 16'h0000);
      step(1, 0, 0, 16'h0);
      chk("hit_a1", imem_bus.imem_addr, 16'h0001);
      chk("hit_v1", 16'(if_valid), 16'h1);
      chk("hit_p0", if_pc, 16'h0000);
      step(1, 0, 0, 16'h0);
      chk("hit_a2", imem_bus.imem_addr, 16'h0002);
      chk("hit_p1", if_pc, 16'h0001);
      chk("hit_p1b", if_pc_plus_one, 16'h0002);
      step(1, 0, 0, 16'h0);
      chk("hit_a3", imem_bus.imem_addr, 16'h0003);
      chk("hit_i2", if_inst, 16'hC302);
      step(1, 0, 0, 16'h0);
      chk("hit_p3", if_pc, 16'h0003);

      // 4-cycle miss at pc=5
      step(0, 0, 0, 16'h0);
      chk("miss_a", imem_bus.imem_addr, 16'h0005);
      chk("miss_p4", if_pc, 16'h0004);
      step(0, 0, 0, 16'h0);
      chk("miss_b", 16'(if_valid), 16'h0);
      step(0, 0, 0, 16'h0);
      chk("miss_req", 16'(imem_bus.imem_req), 16'h1);
      step(1, 0, 0, 16'h0);
      chk("miss_a4", imem_bus.imem_addr, 16'h0005);
      step(1, 0, 0, 16'h0);
      chk("miss_p5", if_pc, 16'h0005);
      chk("miss_i5", if_inst, 16'hC305);

      // decode stall while pc=7 completes
      step(1, 1, 0, 16'h0);
      chk("st_a7", imem_bus.imem_addr, 16'h0007);
      chk("st_p6", if_pc, 16'h0006);
      step(0, 1, 0, 16'h0);
      chk("st_req", 16'(imem_bus.imem_req), 16'h0);
      chk("st_hold", if_pc, 16'h0006);
      step(0, 1, 0, 16'h0);
      chk("st_hold2", if_pc, 16'h0006);
      step(0, 0, 0, 16'h0);
      chk("st_req2", 16'(imem_bus.imem_req), 16'h0);
      step(1, 0, 0, 16'h0);
      chk("st_p7", if_pc, 16'h0007);
      chk("st_a8", imem_bus.imem_addr, 16'h0008);
      step(0, 0, 0, 16'h0);
      chk("st_once", if_pc, 16'h0008);

      // redirect during miss at pc=9
      step(0, 0, 1, 16'h0040);
      chk("rd_a9", imem_bus.imem_addr, 16'h0009);
      step(0, 0, 0, 16'h0);
      chk("rd_drain", imem_bus.imem_addr, 16'h0009);
      chk("rd_v", 16'(if_valid), 16'h0);
      step(1, 0, 0, 16'h0);
      chk("rd_v2", 16'(if_valid), 16'h0);
      step(1, 0, 0, 16'h0);
      chk("rd_a40", imem_bus.imem_addr, 16'h0040);
      chk("rd_v3", 16'(if_valid), 16'h0);

      // redirect and stall together in HOLD, then BTB taken prediction
      step(1, 1, 0, 16'h0);
      chk("hr_p40", if_pc, 16'h0040);
      step(0, 1, 1, 16'h0003);
      chk("hr_req", 16'(imem_bus.imem_req), 16'h0);
      btb_en = 1'b1;
      step(1, 0, 0, 16'h0);
      chk("hr_a3", imem_bus.imem_addr, 16'h0003);
      chk("hr_v", 16'(if_valid), 16'h0);
      step(1, 0, 0, 16'h0);
      chk("btb_a20", imem_bus.imem_addr, 16'h0020);
      chk("btb_pred", if_pred_next, 16'h0020);
      chk("btb_p3", if_pc, 16'h0003);
      step(0, 0, 0, 16'h0);
      chk("btb_a21", imem_bus.imem_addr, 16'h0021);

      // wrap of pc+1 at 16'hFFFF
      step(0, 0, 1, 16'hFFFF);
      step(1, 0, 0, 16'h0);
      step(1, 0, 0, 16'h0);
      chk("wr_aF", imem_bus.imem_addr, 16'hFFFF);
      step(0, 0, 0, 16'h0);
      chk("wr_p", if_pc, 16'hFFFF);
      chk("wr_p1", if_pc_plus_one, 16'h0000);
      chk("wr_a0", imem_bus.imem_addr, 16'h0000);

      // asynchronous reset mid-miss
      step(0, 0, 0, 16'h0);
      #2 reset_n = 1'b0;
      #1 chk_zero("arst");
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;
      step(1, 0, 0, 16'h0);
      chk("ar_a0", imem_bus.imem_addr, 16'h0000);
      step(1, 0, 0, 16'h0);
      chk("ar_p0", if_pc, 16'h0000);
      chk("ar_a1", imem_bus.imem_addr, 16'h0001);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks,
               errors);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- IF stage of the pipelined TSC microcomputer. Holds the PC and issues instruction requests to the instruction cache. Reads the next-PC prediction from the branch target buffer.
- Delivers a valid instruction, its pc, pc+1 and the predicted next PC into the IF/ID register for decode.
- Absorbs variable cache latency, decode stalls and EX-stage redirects on misprediction without losing or duplicating instructions.

Parameters:
- WORD_SIZE, 16, width of PC, instruction and address buses.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- stall_id  input  1  decode hazard: IF/ID must hold its contents this cycle.
- redirect_valid  input  1  EX misprediction: flush and refetch.
- redirect_pc  input  WORD_SIZE  corrected fetch address.
- btb_read_addr  output  WORD_SIZE  equals pc. Lookup address for the BTB.
- btb_read_data  input  WORD_SIZE  predicted next PC, asynchronous BTB read.
- imem_req  output  1  instruction request, held until imem_ready.
- imem_addr  output  WORD_SIZE  request address, stable while imem_req=1.
- imem_ready  input  1  one-cycle pulse; imem_data valid this cycle, completes current request.
- imem_data  input  WORD_SIZE  fetched instruction.
- if_valid  output  1  IF/ID holds a live instruction.
- if_inst  output  WORD_SIZE  IF/ID instruction.
- if_pc  output  WORD_SIZE  address of if_inst.
- if_pc_plus_one  output  WORD_SIZE  if_pc+1, modulo 2^WORD_SIZE.
- if_pred_next  output  WORD_SIZE  BTB prediction used for if_inst.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - pc=RESET_PC; state=FETCH.
  - if_valid=0; if_inst=0; if_pc=0; if_pc_plus_one=0; if_pred_next=0.
  - Hold buffer empty; drain_addr=0.
  - imem_req=0 while reset_n=0.
- Reset released mid-request: any in-flight cache response is not expected; the cache is reset together with this block.
- States: FETCH, HOLD, DRAIN.
- imem_req=1 in FETCH and DRAIN; 0 in HOLD.
- imem_addr=pc in FETCH; drain_addr in DRAIN.
- btb_read_addr=pc always.
- Cache timing: imem_ready may assert in the same cycle as the request (hit) or any later cycle (miss). The block never drops imem_req before imem_ready.
- Priority per cycle: redirect_valid > stall_id > normal fetch.
- FETCH, imem_ready=1, redirect_valid=0, stall_id=0:
  - IF/ID <= {1, imem_data, pc, pc+1, btb_read_data}.
  - pc <= btb_read_data; stay FETCH.
  - Throughput is one instruction per cycle on hits.
- FETCH, imem_ready=1, redirect_valid=0, stall_id=1:
  - IF/ID unchanged.
  - Hold buffer <= {imem_data, pc, pc+1, btb_read_data}; pc <= btb_read_data; go HOLD.
- FETCH, imem_ready=0, redirect_valid=0:
  - stall_id=1: IF/ID unchanged.
  - stall_id=0: if_valid <= 0 (bubble); other IF/ID fields don't care.
- HOLD:
  - stall_id=1: everything holds.
  - stall_id=0: IF/ID <= {1, buffer}; buffer emptied; go FETCH. The next request issues in the following cycle.
- Redirect (redirect_valid=1) in any state: if_valid <= 0, buffer emptied, pc <= redirect_pc. stall_id is ignored.
  - FETCH with imem_ready=1: response discarded; stay FETCH.
  - FETCH with imem_ready=0: drain_addr <= pc (the current imem_addr); go DRAIN.
  - HOLD: go FETCH.
  - DRAIN: pc updated; drain_addr unchanged; if imem_ready=1 go FETCH, else stay DRAIN.
- DRAIN, no redirect: imem_req=1 at drain_addr.
  - On imem_ready: data discarded; go FETCH.
  - if_valid stays 0 while draining.
- Outputs are registered except imem_req, imem_addr and btb_read_addr.
- pc+1 wraps from 16'hFFFF to 16'h0000.
- No instruction is ever delivered twice. No instruction from the wrong path reaches IF/ID after a redirect.

Test Plan:
- Reset, then imem_ready tied high with a BTB holding pc+1 -> imem_addr 0,1,2,3 in consecutive cycles; if_valid=1 from cycle 2; if_pc 0,1,2 with if_pc_plus_one = if_pc+1.
- Miss latency 4 cycles at pc=5 -> imem_req held with imem_addr=5 for 4 cycles; if_valid=0 bubbles; if_inst=imem_data and if_pc=5 one cycle after ready.
- stall_id=1 for 3 cycles while ready pulses at pc=7 -> IF/ID frozen; state HOLD with imem_req=0; after stall drops, if_pc=7 is delivered exactly once, then the fetch resumes at btb_read_data.
- redirect_valid with redirect_pc=16'h0040 during a miss at pc=9 -> imem_addr stays 9 until ready, that data is discarded, next imem_addr=16'h0040, and if_valid=0 throughout.
- Simultaneous redirect and stall_id in HOLD -> buffer flushed, if_valid=0, next imem_addr=redirect_pc. Separately, a BTB entry predicting 16'h0020 from pc=3 -> next imem_addr=16'h0020 and if_pred_next=16'h0020.
- Assert reset_n=0 asynchronously mid-miss -> imem_req drops immediately and all outputs are zero. After release, imem_addr=RESET_PC.
